rtc_bcd_timekeeper: RTL

Time-of-day core for the MyClock design. Sits directly downstream of the free-running 32-bit divider counter. One divider bit, with a 1 s period at board clock, drives tick_src. The block edge-detects that bit and keeps hours:minutes:seconds as six BCD digits in 24-hour format. A set mode adjusts the time from pre-debounced buttons. The digits feed the 7-segment scan driver.

---
 rtl/rtc_bcd_timekeeper.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rtc_bcd_timekeeper.sv
// Time-of-day core: edge-detects a 1 Hz divider bit and keeps HH:MM:SS as six
// BCD digits in 24-hour format, with a button-driven set mode.
module rtc_bcd_timekeeper #(
    parameter logic [7:0] RESET_HH = 8'h12,
    parameter logic [7:0] RESET_MM = 8'h00,
    parameter logic [7:0] RESET_SS = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_src,
    input  logic       run,
    input  logic       set_en,
    input  logic       inc_hr,
    input  logic       inc_min,
    input  logic       clr_sec,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic       sec_tick,
    output logic       min_carry,
    output logic       day_carry
);

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
    } bcd2_t;

    typedef enum logic [1:0] {
        MODE_PAUSE,
        MODE_COUNT,
        MODE_SET
    } mode_e;

    // True at the last legal value of a two-digit field (or beyond it, so an
    // out-of-range value is forced back to 00 instead of propagating).
    function automatic logic at_top(input bcd2_t v, input logic [3:0] hi_top,
                                    input logic [3:0] lo_top);
        return (v.hi > hi_top) || ((v.hi == hi_top) && (v.lo >= lo_top));
    endfunction

    function automatic bcd2_t bcd_inc(input bcd2_t v, input logic [3:0] hi_top,
                                      input logic [3:0] lo_top);
        bcd2_t r;
        if (at_top(v, hi_top, lo_top)) begin
            r = '0;
        end else if (v.lo >= 4'd9) begin
            r.hi = v.hi + 4'd1;
            r.lo = 4'd0;
        end else begin
            r.hi = v.hi;
            r.lo = v.lo + 4'd1;
        end
        return r;
    endfunction

    logic  tick_q, hr_q, min_q, clr_q;
    logic  tick_d, hr_d, min_d, clr_d;
    bcd2_t secs_q, mins_q, hours_q;
    bcd2_t secs_d, mins_d, hours_d;
    logic  sec_tick_q, min_carry_q, day_carry_q;
    logic  sec_tick_d, min_carry_d, day_carry_d;

    logic  sec_en, hr_edge, min_edge, clr_edge;
    mode_e mode;

    assign sec_en   = tick_src & ~tick_q;
    assign hr_edge  = inc_hr   & ~hr_q;
    assign min_edge = inc_min  & ~min_q;
    assign clr_edge = clr_sec  & ~clr_q;

    // Edge registers always track their inputs, whatever the mode.
    assign tick_d = tick_src;
    assign hr_d   = inc_hr;
    assign min_d  = inc_min;
    assign clr_d  = clr_sec;

    always_comb begin
        if (set_en)   mode = MODE_SET;
        else if (run) mode = MODE_COUNT;
        else          mode = MODE_PAUSE;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        secs_d      = secs_q;
        mins_d      = mins_q;
        hours_d     = hours_q;
        sec_tick_d  = sec_en;
        min_carry_d = 1'b0;
        day_carry_d = 1'b0;
        case (mode)
            MODE_COUNT: begin
                if (sec_en) begin
                    secs_d = bcd_inc(secs_q, 4'd5, 4'd9);
                    if (at_top(secs_q, 4'd5, 4'd9)) begin
                        min_carry_d = 1'b1;
                        mins_d      = bcd_inc(mins_q, 4'd5, 4'd9);
                        if (at_top(mins_q, 4'd5, 4'd9)) begin
                            hours_d = bcd_inc(hours_q, 4'd2, 4'd3);
                            if (at_top(hours_q, 4'd2, 4'd3)) day_carry_d = 1'b1;
                        end
                    end
                end
            end
            MODE_SET: begin
                // Each button edits its own field only; no carries out of set mode.
                if (min_edge) mins_d  = bcd_inc(mins_q, 4'd5, 4'd9);
                if (hr_edge)  hours_d = bcd_inc(hours_q, 4'd2, 4'd3);
                if (clr_edge) secs_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Edge registers capture the live input in reset, so a level already
            // high at release is never seen as a fresh edge.
            tick_q      <= tick_src;
            hr_q        <= inc_hr;
            min_q       <= inc_min;
            clr_q       <= clr_sec;
            secs_q      <= RESET_SS;
            mins_q      <= RESET_MM;
            hours_q     <= RESET_HH;
            sec_tick_q  <= 1'b0;
            min_carry_q <= 1'b0;
            day_carry_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            tick_q      <= tick_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            clr_q       <= clr_d;
            secs_q      <= secs_d;
            mins_q      <= mins_d;
            hours_q     <= hours_d;
            sec_tick_q  <= sec_tick_d;
            min_carry_q <= min_carry_d;
            day_carry_q <= day_carry_d;
        end
    end

    assign sec_lo    = secs_q.lo;
    assign sec_hi    = secs_q.hi;
    assign min_lo    = mins_q.lo;
    assign min_hi    = mins_q.hi;
    assign hr_lo     = hours_q.lo;
    assign hr_hi     = hours_q.hi;
    assign sec_tick  = sec_tick_q;
    assign min_carry = min_carry_q;
    assign day_carry = day_carry_q;

endmodule
